// File: rtl/imem_loader.sv
// Instruction memory loader: parses a byte stream (16-bit word count, then
// big-endian 32-bit words) and writes each word to consecutive word addresses.
module imem_loader #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DEPTH      = 4096,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_busy,
  output logic                  o_cpu_hold,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int IDX_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    WFIN   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           shift_q, shift_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  error_q, error_d;

  logic        ready;
  logic        xfer;
  logic [15:0] hdr_count;
  logic        last_word;

  always_comb begin
    ready     = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
    xfer      = i_valid && ready;
    hdr_count = {count_q[15:8], i_byte};
    last_word = (32'(index_q) + 32'd1) == 32'(count_q);
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    index_d    = index_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    error_d    = error_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d    = HDR_HI;
          error_d    = 1'b0;
          index_d    = '0;
          byte_cnt_d = '0;
        end
      end
      HDR_HI: begin
        if (xfer) begin
          count_d[15:8] = i_byte;
          state_d       = HDR_LO;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          count_d[7:0] = i_byte;
          if (hdr_count == 16'd0) begin
            state_d = DONE;
          end else if (32'(hdr_count) > 32'(DEPTH)) begin
            state_d = IDLE;
            error_d = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Fourth byte completes the word; the write fires next cycle.
            we_d    = 1'b1;
            wdata_d = DATA_WIDTH'({shift_q, i_byte});
            waddr_d = ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(index_q) << 2);
            index_d = index_q + IDX_W'(1);
            if (last_word) begin
              state_d = WFIN;
            end
          end else begin
            shift_d = {shift_q[15:0], i_byte};
          end
        end
      end
      WFIN:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      index_q    <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      index_q    <= index_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      error_q    <= error_d;
    end
  end

  assign o_ready    = ready;
  assign o_we       = we_q;
  assign o_waddr    = waddr_q;
  assign o_wdata    = wdata_q;
  assign o_busy     = (state_q != IDLE);
  assign o_cpu_hold = (state_q != IDLE);
  assign o_done     = (state_q == DONE);
  assign o_error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header parsing, word assembly, write timing,
// error handling, reset mid-load and ignored inputs.
module tb_imem_loader;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_valid;
  logic [7:0]  i_byte;
  logic        o_ready, o_we, o_busy, o_cpu_hold, o_done, o_error;
  logic [31:0] o_waddr, o_wdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] waddr_log[$];
  logic [31:0] wdata_log[$];
  int          we_cycles = 0;

  imem_loader #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4096), .BASE_ADDR(0)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid),
    .i_byte(i_byte), .o_ready(o_ready), .o_we(o_we), .o_waddr(o_waddr),
    .o_wdata(o_wdata), .o_busy(o_busy), .o_cpu_hold(o_cpu_hold),
    .o_done(o_done), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  // Every cycle with o_we high is logged mid-cycle, so extra or stuck pulses show up.
  always @(negedge i_clk) begin
    if (o_we) begin
      waddr_log.push_back(o_waddr);
      wdata_log.push_back(o_wdata);
      we_cycles++;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_log();
    waddr_log.delete();
    wdata_log.delete();
    we_cycles = 0;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit sent;
    for (int g = 0; g < gap; g++) begin
      i_valid = 1'b0;
      tick();
    end
    i_valid = 1'b1;
    i_byte  = b;
    sent    = 1'b0;
    for (int k = 0; k < 20 && !sent; k++) begin
      if (o_ready) sent = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    if (!sent) begin
      total++; bad++;
      $display("[TB] FAIL send_byte timeout: byte %h never accepted (ready=%b)", b, o_ready);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_byte = 8'h00;
    tick(); tick();
    total++; if (o_ready !== 1'b0)  begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", o_ready); end
    total++; if (o_we !== 1'b0)     begin bad++; $display("[TB] FAIL reset_we got=%b want=0", o_we); end
    total++; if (o_waddr !== 32'h0) begin bad++; $display("[TB] FAIL reset_waddr got=%h want=0", o_waddr); end
    total++; if (o_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_wdata got=%h want=0", o_wdata); end
    total++; if (o_busy !== 1'b0)   begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", o_busy); end
    total++; if (o_cpu_hold !== 1'b0) begin bad++; $display("[TB] FAIL reset_hold got=%b want=0", o_cpu_hold); end
    total++; if (o_done !== 1'b0)   begin bad++; $display("[TB] FAIL reset_done got=%b want=0", o_done); end
    total++; if (o_error !== 1'b0)  begin bad++; $display("[TB] FAIL reset_error got=%b want=0", o_error); end
    i_rst = 1'b0;
    tick();
  endtask

  // Two-word program, optionally with idle gaps between every byte.
  task automatic run_two_words(input int gap, input string tag);
    logic [7:0] stream [10];
    stream = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h10, 8'h01, 8'h20, 8'h09, 8'h00, 8'h05};
    clear_log();
    do_start();
    total++; if (o_busy !== 1'b1)  begin bad++; $display("[TB] FAIL %s start_busy got=%b want=1", tag, o_busy); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("[TB] FAIL %s start_ready got=%b want=1", tag, o_ready); end
    total++; if (o_cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL %s start_hold got=%b want=1", tag, o_cpu_hold); end
    for (int i = 0; i < 10; i++) send_byte(stream[i], gap);
    total++; if (o_we !== 1'b1)           begin bad++; $display("[TB] FAIL %s last_we got=%b want=1", tag, o_we); end
    total++; if (o_waddr !== 32'h4)       begin bad++; $display("[TB] FAIL %s last_waddr got=%h want=4", tag, o_waddr); end
    total++; if (o_wdata !== 32'h20090005) begin bad++; $display("[TB] FAIL %s last_wdata got=%h want=20090005", tag, o_wdata); end
    total++; if (o_ready !== 1'b0)        begin bad++; $display("[TB] FAIL %s wfin_ready got=%b want=0", tag, o_ready); end
    total++; if (o_done !== 1'b0)         begin bad++; $display("[TB] FAIL %s early_done got=%b want=0", tag, o_done); end
    tick();
    total++; if (o_done !== 1'b1)  begin bad++; $display("[TB] FAIL %s done_pulse got=%b want=1", tag, o_done); end
    total++; if (o_we !== 1'b0)    begin bad++; $display("[TB] FAIL %s we_after got=%b want=0", tag, o_we); end
    total++; if (o_waddr !== 32'h4) begin bad++; $display("[TB] FAIL %s waddr_hold got=%h want=4", tag, o_waddr); end
    total++; if (o_busy !== 1'b1)  begin bad++; $display("[TB] FAIL %s done_busy got=%b want=1", tag, o_busy); end
    tick();
    total++; if (o_busy !== 1'b0)  begin bad++; $display("[TB] FAIL %s idle_busy got=%b want=0", tag, o_busy); end
    total++; if (o_done !== 1'b0)  begin bad++; $display("[TB] FAIL %s idle_done got=%b want=0", tag, o_done); end
    total++; if (we_cycles !== 2)  begin bad++; $display("[TB] FAIL %s we_cycles got=%0d want=2", tag, we_cycles); end
    if (waddr_log.size() >= 2) begin
      total++; if (waddr_log[0] !== 32'h0)        begin bad++; $display("[TB] FAIL %s w0_addr got=%h want=0", tag, waddr_log[0]); end
      total++; if (wdata_log[0] !== 32'h3C081001) begin bad++; $display("[TB] FAIL %s w0_data got=%h want=3c081001", tag, wdata_log[0]); end
      total++; if (waddr_log[1] !== 32'h4)        begin bad++; $display("[TB] FAIL %s w1_addr got=%h want=4", tag, waddr_log[1]); end
      total++; if (wdata_log[1] !== 32'h20090005) begin bad++; $display("[TB] FAIL %s w1_data got=%h want=20090005", tag, wdata_log[1]); end
    end
  endtask

  task automatic test_back_to_back();
    run_two_words(0, "b2b");
  endtask

  task automatic test_gapped();
    run_two_words(3, "gapped");
  endtask

  task automatic test_zero_count();
    clear_log();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    total++; if (o_done !== 1'b1)  begin bad++; $display("[TB] FAIL zero_done got=%b want=1", o_done); end
    total++; if (o_error !== 1'b0) begin bad++; $display("[TB] FAIL zero_error got=%b want=0", o_error); end
    total++; if (o_we !== 1'b0)    begin bad++; $display("[TB] FAIL zero_we got=%b want=0", o_we); end
    tick();
    total++; if (o_busy !== 1'b0)  begin bad++; $display("[TB] FAIL zero_busy got=%b want=0", o_busy); end
    total++; if (we_cycles !== 0)  begin bad++; $display("[TB] FAIL zero_writes got=%0d want=0", we_cycles); end
  endtask

  task automatic test_oversize();
    clear_log();
    do_start();
    send_byte(8'h10, 0);
    send_byte(8'h01, 0);
    total++; if (o_error !== 1'b1) begin bad++; $display("[TB] FAIL over_error got=%b want=1", o_error); end
    total++; if (o_busy !== 1'b0)  begin bad++; $display("[TB] FAIL over_busy got=%b want=0", o_busy); end
    total++; if (o_done !== 1'b0)  begin bad++; $display("[TB] FAIL over_done got=%b want=0", o_done); end
    tick();
    total++; if (o_error !== 1'b1) begin bad++; $display("[TB] FAIL over_sticky got=%b want=1", o_error); end
    total++; if (o_done !== 1'b0)  begin bad++; $display("[TB] FAIL over_done_late got=%b want=0", o_done); end
    do_start();
    total++; if (o_error !== 1'b0) begin bad++; $display("[TB] FAIL over_clear got=%b want=0", o_error); end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    tick();
    total++; if (we_cycles !== 0)  begin bad++; $display("[TB] FAIL over_writes got=%0d want=0", we_cycles); end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] part  [8];
    logic [7:0] fresh [6];
    part  = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h10, 8'h01, 8'h20, 8'h09};
    fresh = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    clear_log();
    do_start();
    for (int i = 0; i < 8; i++) send_byte(part[i], 0);
    i_rst = 1'b1;
    tick();
    total++; if (o_busy !== 1'b0)   begin bad++; $display("[TB] FAIL rmid_busy got=%b want=0", o_busy); end
    total++; if (o_ready !== 1'b0)  begin bad++; $display("[TB] FAIL rmid_ready got=%b want=0", o_ready); end
    total++; if (o_waddr !== 32'h0) begin bad++; $display("[TB] FAIL rmid_waddr got=%h want=0", o_waddr); end
    total++; if (o_wdata !== 32'h0) begin bad++; $display("[TB] FAIL rmid_wdata got=%h want=0", o_wdata); end
    total++; if (o_we !== 1'b0)     begin bad++; $display("[TB] FAIL rmid_we got=%b want=0", o_we); end
    i_rst = 1'b0;
    tick();
    total++; if (o_done !== 1'b0)   begin bad++; $display("[TB] FAIL rmid_done got=%b want=0", o_done); end
    total++; if (we_cycles !== 1)   begin bad++; $display("[TB] FAIL rmid_writes got=%0d want=1", we_cycles); end
    clear_log();
    do_start();
    for (int i = 0; i < 6; i++) send_byte(fresh[i], 0);
    total++; if (o_we !== 1'b1)           begin bad++; $display("[TB] FAIL fresh_we got=%b want=1", o_we); end
    total++; if (o_waddr !== 32'h0)       begin bad++; $display("[TB] FAIL fresh_waddr got=%h want=0", o_waddr); end
    total++; if (o_wdata !== 32'h11223344) begin bad++; $display("[TB] FAIL fresh_wdata got=%h want=11223344", o_wdata); end
    tick(); tick();
  endtask

  task automatic test_ignored_inputs();
    clear_log();
    i_valid = 1'b1;
    i_byte  = 8'hAA;
    tick(); tick(); tick();
    total++; if (o_ready !== 1'b0) begin bad++; $display("[TB] FAIL idle_ready got=%b want=0", o_ready); end
    total++; if (o_busy !== 1'b0)  begin bad++; $display("[TB] FAIL idle_busy got=%b want=0", o_busy); end
    i_valid = 1'b0;
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    do_start();
    total++; if (o_ready !== 1'b1) begin bad++; $display("[TB] FAIL data_start_ready got=%b want=1", o_ready); end
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    total++; if (o_we !== 1'b1)            begin bad++; $display("[TB] FAIL ign_we got=%b want=1", o_we); end
    total++; if (o_waddr !== 32'h0)        begin bad++; $display("[TB] FAIL ign_waddr got=%h want=0", o_waddr); end
    total++; if (o_wdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL ign_wdata got=%h want=deadbeef", o_wdata); end
    tick();
    total++; if (o_done !== 1'b1)  begin bad++; $display("[TB] FAIL ign_done got=%b want=1", o_done); end
    tick();
    total++; if (o_busy !== 1'b0)  begin bad++; $display("[TB] FAIL ign_idle got=%b want=0", o_busy); end
    total++; if (we_cycles !== 1)  begin bad++; $display("[TB] FAIL ign_writes got=%0d want=1", we_cycles); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_zero_count();
    test_oversize();
    test_reset_mid_load();
    test_ignored_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
